lc3_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the LC-3 core. It sits directly upstream of the PC load stage. It drives the PC gate, PC load and PC mux select for the FETCH1 increment. It also latches the gated PC from the shared bus into an internal MAR, runs the memory read handshake, and loads the instruction register. The main control FSM triggers it with `start_fetch` and resumes decode on `fetch_done`.

---
 rtl/lc3_fetch_ctrl_if.sv | 29 ++
 rtl/lc3_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_lc3_fetch_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lc3_fetch_ctrl_if.sv
// Handshake/bus bundle between the LC-3 main control, datapath and the fetch sequencer.
// The slave modport is the fetch sequencer; the master modport is the surrounding core.
interface lc3_fetch_ctrl_if;
  logic        start_fetch;
  logic [15:0] bus;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        gate_pc_en;
  logic        ld_pc;
  logic [1:0]  pc_sel;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] ir;
  logic        fetch_done;
  logic        fetch_err;
  logic        busy;

  modport slave (
    input  start_fetch, bus, mem_rdata, mem_ready,
    output gate_pc_en, ld_pc, pc_sel, mem_rd_en, mem_addr, ir,
           fetch_done, fetch_err, busy
  );

  modport master (
    output start_fetch, bus, mem_rdata, mem_ready,
    input  gate_pc_en, ld_pc, pc_sel, mem_rd_en, mem_addr, ir,
           fetch_done, fetch_err, busy
  );
endinterface

// File: rtl/lc3_fetch_ctrl.sv
// LC-3 instruction-fetch sequencer: IDLE -> MAR -> MEM -> IR, loads MAR/MDR/IR.
// Optional MEM-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module lc3_fetch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  lc3_fetch_ctrl_if.slave fif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAR  = 2'd1,
    S_MEM  = 2'd2,
    S_IR   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] ir_q, ir_d;
  logic        fetch_done_q, fetch_done_d;

`ifdef FETCH_TIMEOUT_EN
  // Counter holds the number of MEM cycles already spent waiting, so the
  // limit cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        fetch_err_q, fetch_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    mar_d        = mar_q;
    mdr_d        = mdr_q;
    ir_d         = ir_q;
    fetch_done_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    fetch_err_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fif.start_fetch) state_d = S_MAR;
      end
      S_MAR: begin
        mar_d   = fif.bus;
        state_d = S_MEM;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = 8'd0;
`endif
      end
      S_MEM: begin
        if (fif.mem_ready) begin
          mdr_d   = fif.mem_rdata;
          state_d = S_IR;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_cnt_q == LIMIT) begin
          state_d     = S_IDLE;
          fetch_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      S_IR: begin
        ir_d         = mdr_q;
        fetch_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mar_q        <= 16'h0000;
      mdr_q        <= 16'h0000;
      ir_q         <= 16'h0000;
      fetch_done_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q   <= 8'd0;
      fetch_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      ir_q         <= ir_d;
      fetch_done_q <= fetch_done_d;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      fetch_err_q  <= fetch_err_d;
`endif
    end
  end

  // Strobes are pure state decodes so they line up with the state cycle itself.
  assign fif.gate_pc_en = (state_q == S_MAR);
  assign fif.ld_pc      = (state_q == S_MAR);
  assign fif.pc_sel     = 2'b00;
  assign fif.mem_rd_en  = (state_q == S_MEM);
  assign fif.mem_addr   = mar_q;
  assign fif.ir         = ir_q;
  assign fif.fetch_done = fetch_done_q;
  assign fif.busy       = (state_q != S_IDLE);
`ifdef FETCH_TIMEOUT_EN
  assign fif.fetch_err  = fetch_err_q;
`else
  assign fif.fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Directed bench for lc3_fetch_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_lc3_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc3_fetch_ctrl_if fif ();

  lc3_fetch_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] bus;
    logic        rdy;
    logic [15:0] rdata;
    logic [39:0] exp;
  } vec_t;

  vec_t tv [40];
  int   nv = 0;

  // {gate, ld, rd_en, busy, done, err, pc_sel[1:0], mem_addr, ir}
  function automatic logic [39:0] e(logic g, logic l, logic r, logic b, logic d,
                                    logic [15:0] a, logic [15:0] i);
    return {g, l, r, b, d, 1'b0, 2'b00, a, i};
  endfunction

  function automatic logic [39:0] obs();
    return {fif.gate_pc_en, fif.ld_pc, fif.mem_rd_en, fif.busy, fif.fetch_done,
            fif.fetch_err, fif.pc_sel, fif.mem_addr, fif.ir};
  endfunction

  task automatic add(logic r, logic s, logic [15:0] b, logic rd, logic [15:0] dat,
                     logic [39:0] ex);
    tv[nv] = '{rst: r, start: s, bus: b, rdy: rd, rdata: dat, exp: ex};
    nv++;
  endtask

  task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dones, errs, memc, first_done, second_done, mars;
    logic [15:0] pc, last_bus, exp_ir, ir0;

    rst = 1'b1;
    fif.start_fetch = 1'b0;
    fif.bus = 16'h0000;
    fif.mem_rdata = 16'h0000;
    fif.mem_ready = 1'b0;

    // reset and idle
    add(1, 0, 16'h0000, 0, 16'h0000, e(0,0,0,0,0,16'h0000,16'h0000));
    add(0, 0, 16'h0000, 0, 16'h0000, e(0,0,0,0,0,16'h0000,16'h0000));
    // single fetch, ready immediately
    add(0, 1, 16'h0000, 0, 16'h0000, e(1,1,0,1,0,16'h0000,16'h0000));
    add(0, 0, 16'h3000, 1, 16'h1261, e(0,0,1,1,0,16'h3000,16'h0000));
    add(0, 0, 16'h0000, 1, 16'h1261, e(0,0,0,1,0,16'h3000,16'h0000));
    add(0, 0, 16'h0000, 0, 16'h0000, e(0,0,0,0,1,16'h3000,16'h1261));
    add(0, 0, 16'h0000, 0, 16'h0000, e(0,0,0,0,0,16'h3000,16'h1261));
    // stray ready in IDLE/MAR, then ready delayed by 3 cycles
    add(0, 0, 16'h0000, 1, 16'hDEAD, e(0,0,0,0,0,16'h3000,16'h1261));
    add(0, 1, 16'h0000, 1, 16'hBEEF, e(1,1,0,1,0,16'h3000,16'h1261));
    add(0, 0, 16'h4000, 1, 16'hBEEF, e(0,0,1,1,0,16'h4000,16'h1261));
    add(0, 0, 16'h0000, 0, 16'h0000, e(0,0,1,1,0,16'h4000,16'h1261));
    add(0, 0, 16'h0000, 0, 16'h0000, e(0,0,1,1,0,16'h4000,16'h1261));
    add(0, 0, 16'h0000, 0, 16'h0000, e(0,0,1,1,0,16'h4000,16'h1261));
    add(0, 0, 16'h0000, 1, 16'h5555, e(0,0,0,1,0,16'h4000,16'h1261));
    add(0, 0, 16'h0000, 0, 16'h0000, e(0,0,0,0,1,16'h4000,16'h5555));
    add(0, 0, 16'h0000, 0, 16'h0000, e(0,0,0,0,0,16'h4000,16'h5555));

    for (int i = 0; i < nv; i++) begin
      rst             = tv[i].rst;
      fif.start_fetch = tv[i].start;
      fif.bus         = tv[i].bus;
      fif.mem_ready   = tv[i].rdy;
      fif.mem_rdata   = tv[i].rdata;
      tick();
      chk($sformatf("vec%0d", i), obs(), tv[i].exp);
    end

    // back-to-back with start_fetch held high
    fif.start_fetch = 1'b1;
    fif.mem_ready   = 1'b1;
    fif.mem_rdata   = 16'h0000;
    pc = 16'h3000; last_bus = 16'h0000; exp_ir = 16'h0000;
    dones = 0; mars = 0; first_done = 0; second_done = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (fif.mem_rd_en)
        chk($sformatf("b2b_addr_c%0d", c), 40'(fif.mem_addr), 40'(last_bus));
      if (fif.fetch_done) begin
        dones++;
        if (dones == 1) first_done = c;
        if (dones == 2) second_done = c;
        chk($sformatf("b2b_ir_c%0d", c), 40'(fif.ir), 40'(exp_ir));
      end
      if (fif.gate_pc_en) begin
        mars++;
        fif.bus       = pc;
        last_bus      = pc;
        exp_ir        = 16'h1200 ^ pc;
        fif.mem_rdata = exp_ir;
        pc            = pc + 16'd1;
      end
    end
    fif.start_fetch = 1'b0;
    chk("b2b_done_count", 40'(dones), 40'd2);
    chk("b2b_first_done", 40'(first_done), 40'd4);
    chk("b2b_spacing", 40'(second_done - first_done), 40'd4);
    chk("b2b_mar_count", 40'(mars), 40'd3);
    for (int c = 0; c < 10 && fif.busy; c++) tick();
    chk("b2b_drain_idle", 40'(fif.busy), 40'd0);

    // reset asserted while in MEM
    fif.start_fetch = 1'b1;
    tick();
    fif.start_fetch = 1'b0;
    fif.mem_ready   = 1'b0;
    fif.bus         = 16'h5000;
    tick();
    chk("rstmem_in_mem", 40'(fif.mem_rd_en), 40'd1);
    rst = 1'b1;
    tick();
    chk("rstmem_after", obs(), e(0,0,0,0,0,16'h0000,16'h0000));
    rst = 1'b0;
    fif.mem_ready = 1'b1;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (fif.fetch_done || fif.busy) dones++;
    end
    chk("rstmem_no_done", 40'(dones), 40'd0);
    fif.mem_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    // timeout with ready held low
    ir0 = fif.ir;
    fif.start_fetch = 1'b1;
    tick();
    fif.start_fetch = 1'b0;
    errs = 0; dones = 0; memc = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (fif.mem_rd_en) memc++;
      if (fif.fetch_done) dones++;
      if (fif.fetch_err) begin
        errs++;
        chk("to_busy_at_err", 40'(fif.busy), 40'd0);
      end
    end
    chk("to_err_count", 40'(errs), 40'd1);
    chk("to_no_done", 40'(dones), 40'd0);
    chk("to_mem_cycles", 40'(memc), 40'd4);
    chk("to_ir_kept", 40'(fif.ir), 40'(ir0));

    // ready arrives in the limit cycle
    fif.start_fetch = 1'b1;
    tick();
    fif.start_fetch = 1'b0;
    fif.mem_rdata   = 16'h7777;
    errs = 0; dones = 0; memc = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (fif.fetch_err) errs++;
      if (fif.fetch_done) begin
        dones++;
        chk("lim_ir", 40'(fif.ir), 40'h7777);
      end
      if (fif.mem_rd_en) begin
        memc++;
        fif.mem_ready = (memc == 4);
      end else begin
        fif.mem_ready = 1'b0;
      end
    end
    chk("lim_done_count", 40'(dones), 40'd1);
    chk("lim_no_err", 40'(errs), 40'd0);
`else
    ir0 = 16'h0000;
    errs = 0;
    fif.start_fetch = 1'b1;
    tick();
    fif.start_fetch = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (fif.fetch_err || !fif.mem_rd_en) errs++;
    end
    chk("nto_waits_forever", 40'(errs), 40'd0);
    chk("nto_ir_kept", 40'(fif.ir), 40'(ir0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
